// File: rtl/fpu_scoreboard.sv
// ---------------------------------------------------------------------------
// fpu_scoreboard
//
// Hazard tracker between FP decode and FP execute. It remembers the FP
// destination register of every accepted multi-cycle operation (FMA pipeline,
// iterative fdiv/fsqrt) until execute reports completion. Decode is stalled on
// RAW, WAW and structural hazards that single-cycle forwarding cannot cover.
//
// Optional feature: define FPU_SCOREBOARD_TIMEOUT_EN to add a watchdog. It
// flags err once TIMEOUT cycles pass with work in flight and no completion.
//
// Parameters
//   MAX_OUT   multi-cycle operations allowed in flight (1..7)
//   TIMEOUT   watchdog limit in cycles (only with FPU_SCOREBOARD_TIMEOUT_EN)
//
// Ports
//   clock, reset                 rising-edge clock, async active-high reset
//   issue_valid/fwren/waddr      decoded instruction and its FP destination
//   issue_frden1..3/raddr1..3    FP source enables and indices
//   issue_multi, issue_div       latency > 1 cycle / uses iterative divider
//   done_valid/fwren/waddr/div   one multi-cycle operation retires
//   flush                        discard all in-flight tracking
//   stall                        instruction must not be accepted this cycle
//   pending                      bit i: FP register i awaits a result
//   count                        multi-cycle operations in flight
//   div_busy                     divider owned
//   err                          sticky protocol / watchdog error
// ---------------------------------------------------------------------------
module fpu_scoreboard #(
    parameter int MAX_OUT = 2,
    parameter int TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_fwren,
    input  logic [4:0]  issue_waddr,
    input  logic        issue_frden1,
    input  logic        issue_frden2,
    input  logic        issue_frden3,
    input  logic [4:0]  issue_raddr1,
    input  logic [4:0]  issue_raddr2,
    input  logic [4:0]  issue_raddr3,
    input  logic        issue_multi,
    input  logic        issue_div,
    input  logic        done_valid,
    input  logic        done_fwren,
    input  logic [4:0]  done_waddr,
    input  logic        done_div,
    input  logic        flush,
    output logic        stall,
    output logic [31:0] pending,
    output logic [2:0]  count,
    output logic        div_busy,
    output logic        err
);

    if (MAX_OUT < 1 || MAX_OUT > 7) begin : g_bad_max_out
        $error("MAX_OUT must be in 1..7");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        DIV  = 1'b1
    } div_state_t;

    div_state_t  state_q, state_d;
    logic [31:0] pending_q;
    logic [2:0]  count_q;
    logic        err_q;

    logic [31:0] clr_mask, eff, set_mask;
    logic        raw, waw, struct_haz, accept;
    logic        done_ok, inc, proto_err, wd_err;

    // A completion presented this cycle already releases its destination, so
    // a dependent instruction issues with zero bubble.
    assign clr_mask = (done_valid && done_fwren) ? (32'd1 << done_waddr) : 32'd0;
    assign eff      = pending_q & ~clr_mask;

    assign raw = (issue_frden1 & eff[issue_raddr1]) |
                 (issue_frden2 & eff[issue_raddr2]) |
                 (issue_frden3 & eff[issue_raddr3]);
    assign waw = issue_fwren & eff[issue_waddr];

    // A retiring operation frees its slot (and the divider) in the same cycle.
    assign struct_haz = (issue_multi & (count_q == 3'(MAX_OUT)) & ~done_valid) |
                        (issue_div & (state_q == DIV) & ~(done_valid & done_div));

    assign stall  = issue_valid & ~flush & (raw | waw | struct_haz);
    assign accept = issue_valid & ~stall & ~flush;

    // A completion with nothing in flight is an error and must not underflow
    // count or disturb pending.
    assign done_ok  = done_valid & (count_q != 3'd0);
    assign inc      = accept & issue_multi;
    assign set_mask = (inc && issue_fwren) ? (32'd1 << issue_waddr) : 32'd0;

    // Completions in a flush cycle are ignored, including for error checks.
    assign proto_err = ~flush & done_valid &
                       ((count_q == 3'd0) |
                        (done_fwren & ~pending_q[done_waddr]) |
                        (done_div & (state_q == IDLE)));

    // NOTE: every signal assigned in always_comb gets a default first so no
    // latch is inferred on paths that do not assign it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && issue_div) state_d = DIV;
            DIV:  if (done_valid && done_div && !(accept && issue_div)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= 32'd0;
            count_q   <= 3'd0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_q | proto_err | wd_err;
            if (flush) begin
                pending_q <= 32'd0;
                count_q   <= 3'd0;
            end else begin
                // Clear before set: a new issue to the same index wins.
                pending_q <= (done_ok ? eff : pending_q) | set_mask;
                count_q   <= count_q + 3'(inc) - 3'(done_ok);
            end
        end
    end

`ifdef FPU_SCOREBOARD_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q;

    // Counts idle cycles with work in flight; saturates at TIMEOUT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_q <= '0;
        end else if (flush || done_valid) begin
            wd_q <= '0;
        end else if (count_q != 3'd0 && wd_q != WD_W'(TIMEOUT)) begin
            wd_q <= wd_q + 1'b1;
        end
    end

    assign wd_err = (wd_q == WD_W'(TIMEOUT));
`else
    assign wd_err = 1'b0;
`endif

    assign pending  = pending_q;
    assign count    = count_q;
    assign div_busy = (state_q == DIV);
    assign err      = err_q;

endmodule
